counter_checker: RTL

Receive-side checker for a free-running up-counter bus, such as the 32-bit `counter_out` of our counter blocks.
- Samples the incoming count when qualified and verifies each new value equals the previous value + 1, modulo 2^WIDTH.
- Reports lock status, flags mismatches and keeps a saturating error tally.
- Sits on the consumer side of the counter link, in the same CLOCK_5 domain, as a board-level sanity monitor.

---
 rtl/counter_checker_if.sv | 25 ++
 rtl/counter_checker.sv | 96 +++++++++
 2 files changed

// File: rtl/counter_checker_if.sv
// Observed-counter bus between the counter link tap and the checker: sample/clear in, status out.
// The monitor side drives the sample stream; the checker side returns lock and error status.
interface counter_checker_if #(
   parameter int WIDTH     = 32,
   parameter int ERR_CNT_W = 16
);
   logic [WIDTH-1:0]     counter_in;
   logic                 in_valid;
   logic                 clear_errors;
   logic                 locked;
   logic                 error_pulse;
   logic [ERR_CNT_W-1:0] error_count;
   logic [WIDTH-1:0]     expected_value;
   logic [WIDTH-1:0]     last_value;

   modport master (
      output counter_in, in_valid, clear_errors,
      input  locked, error_pulse, error_count, expected_value, last_value
   );

   modport slave (
      input  counter_in, in_valid, clear_errors,
      output locked, error_pulse, error_count, expected_value, last_value
   );
endinterface

// File: rtl/counter_checker.sv
// Verifies a sampled up-counter stream increments by one; all outputs registered, latency 1.
// No backpressure: samples are taken whenever in_valid is high, idle cycles hold state.
module counter_checker #(
   parameter int WIDTH      = 32,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic CLOCK_5,
   input  logic RESET_N,
   counter_checker_if.slave bus
);
   localparam int CNT_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      UNLOCKED = 2'b00,
      ACQUIRE  = 2'b01,
      LOCKED   = 2'b10
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     match_cnt;
   logic                 locked_q;
   logic                 error_pulse_q;
   logic [ERR_CNT_W-1:0] error_count_q;
   logic [WIDTH-1:0]     expected_q;
   logic [WIDTH-1:0]     last_q;

   logic             is_match;
   logic             err_evt;
   logic [CNT_W-1:0] match_cnt_inc;

   assign is_match      = (bus.counter_in == expected_q);
   assign err_evt       = bus.in_valid && (state == LOCKED) && !is_match;
   assign match_cnt_inc = match_cnt + 1'b1;

   always_ff @(posedge CLOCK_5 or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= UNLOCKED;
         match_cnt     <= '0;
         locked_q      <= 1'b0;
         error_pulse_q <= 1'b0;
         error_count_q <= '0;
         expected_q    <= '0;
         last_q        <= '0;
      end else begin
         error_pulse_q <= err_evt;

         // Clear takes priority over a coincident increment.
         if (bus.clear_errors)
            error_count_q <= '0;
         else if (err_evt && (error_count_q != '1))
            error_count_q <= error_count_q + 1'b1;

         if (bus.in_valid) begin
            last_q     <= bus.counter_in;
            expected_q <= bus.counter_in + 1'b1;
            case (state)
               UNLOCKED: begin
                  match_cnt <= '0;
                  state     <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (is_match) begin
                     match_cnt <= match_cnt_inc;
                     if (match_cnt_inc == LOCK_TGT) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!is_match) begin
                     locked_q  <= 1'b0;
                     match_cnt <= '0;
                     state     <= ACQUIRE;
                  end
               end
               default: begin
                  locked_q  <= 1'b0;
                  match_cnt <= '0;
                  state     <= UNLOCKED;
               end
            endcase
         end
      end
   end

   assign bus.locked         = locked_q;
   assign bus.error_pulse    = error_pulse_q;
   assign bus.error_count    = error_count_q;
   assign bus.expected_value = expected_q;
   assign bus.last_value     = last_q;
endmodule
